// File: rtl/syn_fifo_prog.sv
// syn_fifo_prog: single-clock sample-buffer FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags, synchronous flush and a read-data valid strobe.
// Build option: define SYN_FIFO_FWFT_EN for first-word-fall-through output;
// without it the FIFO has a registered read with one cycle of latency.
module syn_fifo_prog #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic [ADDR_WIDTH:0]   aempty_thr,
    input  logic [ADDR_WIDTH:0]   afull_thr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  alempty,
    output logic                  alfull,
    output logic                  ovf,
    output logic                  udf
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                wr_acc;
    logic                rd_acc;
    logic                udf_evt;

    assign count   = wptr - rptr;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign alempty = (count <= aempty_thr);
    assign alfull  = (count >= afull_thr);

    // A full FIFO rejects writes even when a read is popping in the same cycle.
    assign wr_acc = wen & ~full & ~clr;

    // Storage write port.
    // NOTE: the RAM array has no reset; clearing thousands of words would
    // block RAM inference, and stale contents are unreachable behind the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    // Write pointer: advances on each accepted write, zeroed by flush.
    // NOTE: state is always updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
        end else if (clr) begin
            wptr <= '0;
        end else if (wr_acc) begin
            wptr <= wptr + PTR_ONE;
        end
    end

`ifdef SYN_FIFO_FWFT_EN

    // raddr runs ahead of rptr by one while a word sits in the output register;
    // count = wptr - rptr therefore includes the presented word.
    logic [ADDR_WIDTH:0] raddr;
    logic                ram_rdy;
    logic                load;

    assign rd_acc  = ren & dout_vld & ~clr;
    assign ram_rdy = (wptr != raddr);
    assign load    = ram_rdy & (~dout_vld | rd_acc) & ~clr;
    assign udf_evt = ren & ~dout_vld;

    // Pop pointer and prefetch address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            raddr <= '0;
        end else if (clr) begin
            rptr  <= '0;
            raddr <= '0;
        end else begin
            if (rd_acc) rptr  <= rptr + PTR_ONE;
            if (load)   raddr <= raddr + PTR_ONE;
        end
    end

    // Output register: refilled whenever it is empty or being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            dout <= mem[raddr[ADDR_WIDTH-1:0]];
        end
    end

    // Presented-word valid: set by a prefetch, cleared by a pop with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_vld <= 1'b0;
        end else if (clr) begin
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= load | (dout_vld & ~rd_acc);
        end
    end

`else

    assign rd_acc  = ren & ~empty & ~clr;
    assign udf_evt = ren & empty;

    // Read pointer: advances on each accepted read, zeroed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
        end else if (clr) begin
            rptr <= '0;
        end else if (rd_acc) begin
            rptr <= rptr + PTR_ONE;
        end
    end

    // Registered read data; holds its value between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (rd_acc) begin
            dout <= mem[rptr[ADDR_WIDTH-1:0]];
        end
    end

    // Valid strobe: high for exactly the cycle after an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_vld <= 1'b0;
        end else if (clr) begin
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= rd_acc;
        end
    end

`endif

    // Sticky error flags; flush clears them and its own wen/ren set nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wen & full) ovf <= 1'b1;
            if (udf_evt)    udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Directed testbench for syn_fifo_prog with DEPTH = 8 (ADDR_WIDTH = 3).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the edge just taken.
`timescale 1ns/1ps
module tb_syn_fifo_prog;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wen;
    logic [DW-1:0] din;
    logic          ren;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic [AW:0]   aempty_thr;
    logic [AW:0]   afull_thr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          alempty;
    logic          alfull;
    logic          ovf;
    logic          udf;

    int total = 0;
    int bad   = 0;

    syn_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .din(din), .ren(ren),
        .dout(dout), .dout_vld(dout_vld), .aempty_thr(aempty_thr), .afull_thr(afull_thr),
        .count(count), .empty(empty), .full(full), .alempty(alempty), .alfull(alfull),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
        aempty_thr = 4'd2; afull_thr = 4'd0;
        tick(); tick();
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || alempty !== 1'b1) begin
            bad++;
            $display("FAIL reset_cnt_flags got cnt=%0d e=%b f=%b ae=%b exp cnt=0 e=1 f=0 ae=1",
                     count, empty, full, alempty);
        end
        total++;
        if (alfull !== 1'b1) begin
            bad++; $display("FAIL reset_alfull_thr0 got=%b exp=1", alfull);
        end
        total++;
        if (ovf !== 1'b0 || udf !== 1'b0 || dout_vld !== 1'b0 || dout !== 16'h0) begin
            bad++;
            $display("FAIL reset_out got ovf=%b udf=%b vld=%b dout=%h exp 0 0 0 0000",
                     ovf, udf, dout_vld, dout);
        end
        afull_thr = 4'd6;
        #1;
        total++;
        if (alfull !== 1'b0) begin
            bad++; $display("FAIL reset_alfull_thr6 got=%b exp=0", alfull);
        end
        rst_n = 1'b1;
        tick();
    endtask

`ifdef SYN_FIFO_FWFT_EN

    task automatic test_fwft();
        wen = 1'b1; din = 16'h0055; tick();
        wen = 1'b0;
        total++;
        if (count !== 4'd1 || dout_vld !== 1'b0) begin
            bad++; $display("FAIL fwft_wr1 got cnt=%0d vld=%b exp cnt=1 vld=0", count, dout_vld);
        end
        tick();
        total++;
        if (dout !== 16'h0055 || dout_vld !== 1'b1) begin
            bad++; $display("FAIL fwft_present got dout=%h vld=%b exp 0055 1", dout, dout_vld);
        end
        wen = 1'b1; din = 16'h0066; tick();
        wen = 1'b0;
        total++;
        if (count !== 4'd2 || dout !== 16'h0055 || dout_vld !== 1'b1) begin
            bad++; $display("FAIL fwft_hold got cnt=%0d dout=%h vld=%b exp 2 0055 1", count, dout, dout_vld);
        end
        ren = 1'b1; tick();
        total++;
        if (count !== 4'd1 || dout !== 16'h0066 || dout_vld !== 1'b1) begin
            bad++; $display("FAIL fwft_pop1 got cnt=%0d dout=%h vld=%b exp 1 0066 1", count, dout, dout_vld);
        end
        tick();
        total++;
        if (count !== 4'd0 || dout_vld !== 1'b0 || udf !== 1'b0) begin
            bad++; $display("FAIL fwft_pop2 got cnt=%0d vld=%b udf=%b exp 0 0 0", count, dout_vld, udf);
        end
        tick();
        ren = 1'b0;
        total++;
        if (udf !== 1'b1 || count !== 4'd0) begin
            bad++; $display("FAIL fwft_udf got udf=%b cnt=%0d exp 1 0", udf, count);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        total++;
        if (udf !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL fwft_clr got udf=%b e=%b exp 0 1", udf, empty);
        end
    endtask

`else

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            wen = 1'b1; din = 16'h00A0 + 16'(i); tick();
            total++;
            if (count !== 4'(i + 1) || empty !== 1'b0) begin
                bad++; $display("FAIL basic_wr[%0d] got cnt=%0d e=%b exp cnt=%0d e=0", i, count, empty, i + 1);
            end
        end
        wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ren = 1'b1; tick();
            total++;
            if (dout !== 16'h00A0 + 16'(i) || dout_vld !== 1'b1 || count !== 4'(3 - i)) begin
                bad++;
                $display("FAIL basic_rd[%0d] got dout=%h vld=%b cnt=%0d exp dout=%h vld=1 cnt=%0d",
                         i, dout, dout_vld, count, 16'h00A0 + 16'(i), 3 - i);
            end
        end
        ren = 1'b0;
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL basic_empty got=%b exp=1", empty);
        end
        tick();
        total++;
        if (dout_vld !== 1'b0 || dout !== 16'h00A3 || udf !== 1'b0) begin
            bad++; $display("FAIL basic_idle got vld=%b dout=%h udf=%b exp 0 00a3 0", dout_vld, dout, udf);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 9; i++) begin
            wen = 1'b1; din = 16'h0010 + 16'(i); tick();
            total++;
            if (count !== 4'((i < 8) ? i + 1 : 8) || full !== (i >= 7) || ovf !== (i == 8)) begin
                bad++;
                $display("FAIL full_wr[%0d] got cnt=%0d f=%b ovf=%b exp cnt=%0d f=%b ovf=%b",
                         i, count, full, ovf, (i < 8) ? i + 1 : 8, i >= 7, i == 8);
            end
        end
        ren = 1'b1; din = 16'h00EE; tick();
        wen = 1'b0;
        total++;
        if (count !== 4'd7 || dout !== 16'h0010 || dout_vld !== 1'b1 || full !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL full_wr_rd got cnt=%0d dout=%h vld=%b f=%b ovf=%b exp 7 0010 1 0 1",
                     count, dout, dout_vld, full, ovf);
        end
        for (int i = 1; i < 8; i++) begin
            tick();
            total++;
            if (dout !== 16'h0010 + 16'(i) || count !== 4'(7 - i)) begin
                bad++;
                $display("FAIL full_rd[%0d] got dout=%h cnt=%0d exp dout=%h cnt=%0d",
                         i, dout, count, 16'h0010 + 16'(i), 7 - i);
            end
        end
        ren = 1'b0;
        tick();
        total++;
        if (empty !== 1'b1 || dout_vld !== 1'b0 || udf !== 1'b0) begin
            bad++; $display("FAIL full_drained got e=%b vld=%b udf=%b exp 1 0 0", empty, dout_vld, udf);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL full_clr_ovf got=%b exp=0", ovf);
        end
    endtask

    task automatic test_underflow_clr();
        ren = 1'b1; tick();
        total++;
        if (udf !== 1'b1 || dout_vld !== 1'b0 || count !== 4'd0 || dout !== 16'h0017) begin
            bad++;
            $display("FAIL udf_empty got udf=%b vld=%b cnt=%0d dout=%h exp 1 0 0 0017",
                     udf, dout_vld, count, dout);
        end
        wen = 1'b1; din = 16'h0077; tick();
        total++;
        if (count !== 4'd1 || empty !== 1'b0 || udf !== 1'b1 || dout_vld !== 1'b0) begin
            bad++;
            $display("FAIL udf_wr_rd got cnt=%0d e=%b udf=%b vld=%b exp 1 0 1 0", count, empty, udf, dout_vld);
        end
        clr = 1'b1; din = 16'h0088; tick();
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || udf !== 1'b0 || ovf !== 1'b0 || dout_vld !== 1'b0
            || dout !== 16'h0017) begin
            bad++;
            $display("FAIL clr_prio got cnt=%0d e=%b udf=%b ovf=%b vld=%b dout=%h exp 0 1 0 0 0 0017",
                     count, empty, udf, ovf, dout_vld, dout);
        end
        clr = 1'b0; wen = 1'b0; tick();
        total++;
        if (udf !== 1'b1 || dout_vld !== 1'b0 || count !== 4'd0) begin
            bad++; $display("FAIL clr_flushed got udf=%b vld=%b cnt=%0d exp 1 0 0", udf, dout_vld, count);
        end
        ren = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_thresholds();
        aempty_thr = 4'd2; afull_thr = 4'd6;
        #1;
        total++;
        if (alempty !== 1'b1 || alfull !== 1'b0) begin
            bad++; $display("FAIL thr_c0 got ae=%b af=%b exp 1 0", alempty, alfull);
        end
        for (int c = 1; c <= 8; c++) begin
            wen = 1'b1; din = 16'h0300 + 16'(c); tick();
            total++;
            if (count !== 4'(c) || alempty !== (c <= 2) || alfull !== (c >= 6)) begin
                bad++;
                $display("FAIL thr_up[%0d] got cnt=%0d ae=%b af=%b exp ae=%b af=%b",
                         c, count, alempty, alfull, c <= 2, c >= 6);
            end
        end
        wen = 1'b0;
        afull_thr = 4'd9;
        #1;
        total++;
        if (alfull !== 1'b0) begin
            bad++; $display("FAIL thr_live got af=%b exp 0", alfull);
        end
        afull_thr = 4'd6;
        for (int c = 7; c >= 0; c--) begin
            ren = 1'b1; tick();
            total++;
            if (count !== 4'(c) || alempty !== (c <= 2) || alfull !== (c >= 6)
                || dout !== 16'h0300 + 16'(8 - c)) begin
                bad++;
                $display("FAIL thr_dn[%0d] got cnt=%0d ae=%b af=%b dout=%h exp ae=%b af=%b dout=%h",
                         c, count, alempty, alfull, dout, c <= 2, c >= 6, 16'h0300 + 16'(8 - c));
            end
        end
        ren = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; din = 16'h0400 + 16'(i); tick();
        end
        for (int k = 0; k < 20; k++) begin
            wen = 1'b1; ren = 1'b1; din = 16'h0403 + 16'(k); tick();
            total++;
            if (count !== 4'd3 || dout !== 16'h0400 + 16'(k) || dout_vld !== 1'b1) begin
                bad++;
                $display("FAIL stream[%0d] got cnt=%0d dout=%h vld=%b exp 3 %h 1",
                         k, count, dout, dout_vld, 16'h0400 + 16'(k));
            end
        end
        wen = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            total++;
            if (dout !== 16'h0414 + 16'(j) || count !== 4'(2 - j)) begin
                bad++;
                $display("FAIL stream_drain[%0d] got dout=%h cnt=%0d exp %h %0d",
                         j, dout, count, 16'h0414 + 16'(j), 2 - j);
            end
        end
        ren = 1'b0;
        tick();
        total++;
        if (empty !== 1'b1 || udf !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL stream_end got e=%b udf=%b ovf=%b exp 1 0 0", empty, udf, ovf);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; din = 16'h0500 + 16'(i); tick();
        end
        wen = 1'b0;
        ren = 1'b1; tick(); ren = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (count !== 4'd0 || empty !== 1'b1 || dout !== 16'h0 || dout_vld !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got cnt=%0d e=%b dout=%h vld=%b exp 0 1 0000 0", count, empty, dout, dout_vld);
        end
        #1 rst_n = 1'b1;
        wen = 1'b1; din = 16'h0099; tick();
        wen = 1'b0;
        total++;
        if (count !== 4'd1) begin
            bad++; $display("FAIL rst_mid_wr got cnt=%0d exp 1", count);
        end
        ren = 1'b1; tick(); ren = 1'b0;
        total++;
        if (dout !== 16'h0099 || dout_vld !== 1'b1 || count !== 4'd0) begin
            bad++; $display("FAIL rst_mid_rd got dout=%h vld=%b cnt=%0d exp 0099 1 0", dout, dout_vld, count);
        end
        tick();
    endtask

`endif

    initial begin
        test_reset();
`ifdef SYN_FIFO_FWFT_EN
        test_fwft();
`else
        test_basic();
        test_full();
        test_underflow_clr();
        test_thresholds();
        test_streaming();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
